// File: rtl/smc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : smc_pkg
// Description : Shared constants for the SMC region checker: config select
//               encodings, ctrl-word bit positions and default parameters.
// Revision    : 1.0 - initial release
// ============================================================================
package smc_pkg;

    localparam int DEFAULT_NUM_REGIONS = 4;
    localparam int DEFAULT_AW          = 32;
    localparam int DEFAULT_CW          = 16;

    // cfg_sel encodings
    localparam logic [1:0] C_SEL_LOW  = 2'd0;
    localparam logic [1:0] C_SEL_HIGH = 2'd1;
    localparam logic [1:0] C_SEL_CTRL = 2'd2;
    localparam logic [1:0] C_SEL_CLR  = 2'd3;

    // ctrl word bit positions
    localparam int C_CTRL_EN   = 0;
    localparam int C_CTRL_LOCK = 1;
    localparam int C_CTRL_RD   = 2;
    localparam int C_CTRL_WR   = 3;

endpackage
`default_nettype wire

// File: rtl/smc_region_cmp.sv
`default_nettype none
// ============================================================================
// Module      : smc_region_cmp
// Description : One SMC bound region: low/high bounds, ctrl bits and the
//               combinational inclusive-range / access-type match.
// Revision    : 1.0 - initial release
// ============================================================================
module smc_region_cmp
    import smc_pkg::*;
#(
    parameter int AW = DEFAULT_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_stb,     // accepted write to this region
    input  logic [1:0]    wr_sel,
    input  logic [AW-1:0] wr_data,
    input  logic [AW-1:0] chk_addr,
    input  logic          chk_we,
    output logic          match,
    output logic          locked
);

    logic [AW-1:0] r_low;
    logic [AW-1:0] r_high;
    logic          r_en;
    logic          r_lock;
    logic          r_rd_en;
    logic          r_wr_en;

    // Region registers; lock is sticky until reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_low   <= '0;
            r_high  <= '0;
            r_en    <= 1'b0;
            r_lock  <= 1'b0;
            r_rd_en <= 1'b0;
            r_wr_en <= 1'b0;
        end else if (wr_stb) begin
            case (wr_sel)
                C_SEL_LOW:  r_low  <= wr_data;
                C_SEL_HIGH: r_high <= wr_data;
                C_SEL_CTRL: begin
                    r_en    <= wr_data[C_CTRL_EN];
                    r_lock  <= r_lock | wr_data[C_CTRL_LOCK];
                    r_rd_en <= wr_data[C_CTRL_RD];
                    r_wr_en <= wr_data[C_CTRL_WR];
                end
                default: ;
            endcase
        end
    end

    // low > high can never satisfy both comparisons, so no explicit check needed
    assign match  = r_en && (chk_addr >= r_low) && (chk_addr <= r_high) &&
                    (chk_we ? r_wr_en : r_rd_en);
    assign locked = r_lock;

endmodule
`default_nettype wire

// File: rtl/smc_region_check.sv
`default_nettype none
// ============================================================================
// Module      : smc_region_check
// Description : Multi-region SMC bound checker: per-region comparators,
//               lowest-index priority encoder, registered result, config
//               error pulse and saturating hit counter.
// Revision    : 1.0 - initial release
// ============================================================================
module smc_region_check
    import smc_pkg::*;
#(
    parameter  int NUM_REGIONS = DEFAULT_NUM_REGIONS,
    parameter  int AW          = DEFAULT_AW,
    parameter  int CW          = DEFAULT_CW,
    localparam int IDXW        = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cfg_we,
    input  logic [IDXW-1:0] cfg_idx,
    input  logic [1:0]      cfg_sel,
    input  logic [AW-1:0]   cfg_wdata,
    output logic            cfg_err,
    input  logic            chk_valid,
    input  logic [AW-1:0]   chk_addr,
    input  logic            chk_we,
    output logic            res_valid,
    output logic            res_hit,
    output logic [IDXW-1:0] res_idx,
    output logic [CW-1:0]   hit_cnt
);

    logic [NUM_REGIONS-1:0] w_match;
    logic [NUM_REGIONS-1:0] w_lock;
    logic [NUM_REGIONS-1:0] w_wr_stb;
    logic                   w_idx_ok;
    logic                   w_sel_locked;
    logic                   w_reject;
    logic                   w_clr;
    logic                   w_any;
    logic                   w_hit;
    logic [IDXW-1:0]        w_enc;

    logic                   r_cfg_err;
    logic                   r_res_valid;
    logic                   r_res_hit;
    logic [IDXW-1:0]        r_res_idx;
    logic [CW-1:0]          r_hit_cnt;

    assign w_idx_ok = (32'(cfg_idx) < NUM_REGIONS);
    assign w_clr    = cfg_we && (cfg_sel == C_SEL_CLR);
    assign w_reject = cfg_we && (cfg_sel != C_SEL_CLR) && (!w_idx_ok || w_sel_locked);

    generate
        for (genvar gi = 0; gi < NUM_REGIONS; gi++) begin : g_region
            assign w_wr_stb[gi] = cfg_we && (cfg_sel != C_SEL_CLR) &&
                                  (cfg_idx == IDXW'(gi)) && !w_lock[gi];

            smc_region_cmp #(
                .AW (AW)
            ) u_cmp (
                .clk      (clk),
                .rst_n    (rst_n),
                .wr_stb   (w_wr_stb[gi]),
                .wr_sel   (cfg_sel),
                .wr_data  (cfg_wdata),
                .chk_addr (chk_addr),
                .chk_we   (chk_we),
                .match    (w_match[gi]),
                .locked   (w_lock[gi])
            );
        end
    endgenerate

    // Lock state of the addressed region (out-of-range index reads as unlocked)
    always_comb begin
        w_sel_locked = 1'b0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (cfg_idx == IDXW'(i)) w_sel_locked = w_lock[i];
        end
    end

    // Priority encoder: scan downward so the lowest matching index wins
    always_comb begin
        w_any = 1'b0;
        w_enc = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                w_any = 1'b1;
                w_enc = IDXW'(i);
            end
        end
    end

    assign w_hit = chk_valid && w_any;

    // Result register and config error pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_valid <= 1'b0;
            r_res_hit   <= 1'b0;
            r_res_idx   <= '0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_res_valid <= chk_valid;
            r_res_hit   <= w_hit;
            r_res_idx   <= w_hit ? w_enc : '0;
            r_cfg_err   <= w_reject;
        end
    end

    // Saturating hit counter, updated alongside res_hit; clear has priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_cnt <= '0;
        end else if (w_clr) begin
            r_hit_cnt <= '0;
        end else if (w_hit && (r_hit_cnt != '1)) begin
            r_hit_cnt <= r_hit_cnt + 1'b1;
        end
    end

    assign cfg_err   = r_cfg_err;
    assign res_valid = r_res_valid;
    assign res_hit   = r_res_hit;
    assign res_idx   = r_res_idx;
    assign hit_cnt   = r_hit_cnt;

endmodule
`default_nettype wire

// File: tb/tb_smc_region_check.sv
`default_nettype none
// ============================================================================
// Module      : tb_smc_region_check
// Description : Directed, table-driven bench for smc_region_check
//               (3 regions so an out-of-range index exists, 4-bit counter).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_smc_region_check;

    localparam int C_NR   = 3;
    localparam int C_AW   = 32;
    localparam int C_CW   = 4;
    localparam int C_IDXW = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cfg_we;
    logic [C_IDXW-1:0] cfg_idx;
    logic [1:0]        cfg_sel;
    logic [C_AW-1:0]   cfg_wdata;
    logic              cfg_err;
    logic              chk_valid;
    logic [C_AW-1:0]   chk_addr;
    logic              chk_we;
    logic              res_valid;
    logic              res_hit;
    logic [C_IDXW-1:0] res_idx;
    logic [C_CW-1:0]   hit_cnt;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic        valid;
        logic [31:0] addr;
        logic        we;
        logic        exp_hit;
        logic [1:0]  exp_idx;
    } vec_t;

    vec_t tbl_a[5];
    vec_t tbl_b[8];

    smc_region_check #(
        .NUM_REGIONS (C_NR),
        .AW          (C_AW),
        .CW          (C_CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_sel   (cfg_sel),
        .cfg_wdata (cfg_wdata),
        .cfg_err   (cfg_err),
        .chk_valid (chk_valid),
        .chk_addr  (chk_addr),
        .chk_we    (chk_we),
        .res_valid (res_valid),
        .res_hit   (res_hit),
        .res_idx   (res_idx),
        .hit_cnt   (hit_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled at the falling edge
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_chk(input logic v, input logic [31:0] a, input logic w);
        chk_valid = v;
        chk_addr  = a;
        chk_we    = w;
    endtask

    task automatic cfg_wr(input logic [1:0] idx, input logic [1:0] sel,
                          input logic [31:0] data, input logic exp_err);
        cfg_we    = 1'b1;
        cfg_idx   = idx;
        cfg_sel   = sel;
        cfg_wdata = data;
        tick();
        cfg_we = 1'b0;
        check($sformatf("cfg_err idx%0d sel%0d", idx, sel), 32'(cfg_err), 32'(exp_err));
    endtask

    task automatic check_res(input string name, input logic v, input logic h, input logic [1:0] idx);
        check({name, ".valid"}, 32'(res_valid), 32'(v));
        check({name, ".hit"},   32'(res_hit),   32'(h));
        check({name, ".idx"},   32'(res_idx),   32'(idx));
    endtask

    task automatic run_vec(input vec_t v);
        set_chk(v.valid, v.addr, v.we);
        tick();
        check_res(v.name, v.valid, v.exp_hit, v.exp_idx);
    endtask

    task automatic check_all_zero(input string name);
        check_res(name, 1'b0, 1'b0, 2'd0);
        check({name, ".hit_cnt"}, 32'(hit_cnt), 32'd0);
        check({name, ".cfg_err"}, 32'(cfg_err), 32'd0);
    endtask

    initial begin
        int exp_cnt;

        // name, valid, addr, we, exp_hit, exp_idx
        tbl_a[0] = '{"r0_below",   1'b1, 32'h0000_0FFF, 1'b0, 1'b0, 2'd0};
        tbl_a[1] = '{"r0_low",     1'b1, 32'h0000_1000, 1'b0, 1'b1, 2'd0};
        tbl_a[2] = '{"r0_high",    1'b1, 32'h0000_1FFF, 1'b0, 1'b1, 2'd0};
        tbl_a[3] = '{"r0_above",   1'b1, 32'h0000_2000, 1'b0, 1'b0, 2'd0};
        tbl_a[4] = '{"r0_idle",    1'b0, 32'h0000_1500, 1'b0, 1'b0, 2'd0};

        tbl_b[0] = '{"ovl_1900",   1'b1, 32'h0000_1900, 1'b0, 1'b1, 2'd0};
        tbl_b[1] = '{"r1_2100",    1'b1, 32'h0000_2100, 1'b0, 1'b1, 2'd1};
        tbl_b[2] = '{"r1_high",    1'b1, 32'h0000_2800, 1'b0, 1'b1, 2'd1};
        tbl_b[3] = '{"r1_above",   1'b1, 32'h0000_2801, 1'b0, 1'b0, 2'd0};
        tbl_b[4] = '{"ovl_st",     1'b1, 32'h0000_1900, 1'b1, 1'b1, 2'd0};
        tbl_b[5] = '{"ovl_idle",   1'b0, 32'h0000_1900, 1'b0, 1'b0, 2'd0};
        tbl_b[6] = '{"r2_locked",  1'b1, 32'h0000_5000, 1'b0, 1'b0, 2'd0};
        tbl_b[7] = '{"r2_st",      1'b1, 32'h0000_5800, 1'b1, 1'b0, 2'd0};

        rst_n = 1'b0;
        cfg_we = 1'b0; cfg_idx = '0; cfg_sel = '0; cfg_wdata = '0;
        set_chk(1'b0, 32'd0, 1'b0);
        tick();
        tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Region0 bounds; ctrl written in the same cycle as a check in range
        cfg_wr(2'd0, 2'd0, 32'h0000_1000, 1'b0);
        cfg_wr(2'd0, 2'd1, 32'h0000_1FFF, 1'b0);
        cfg_we = 1'b1; cfg_idx = 2'd0; cfg_sel = 2'd2; cfg_wdata = 32'hD;
        set_chk(1'b1, 32'h0000_1000, 1'b0);
        tick();
        cfg_we = 1'b0;
        check_res("same_cyc_pre", 1'b1, 1'b0, 2'd0);
        tick();
        check_res("same_cyc_post", 1'b1, 1'b1, 2'd0);

        foreach (tbl_a[i]) run_vec(tbl_a[i]);

        // Region1 overlapping region0; region2 locked with no access types
        set_chk(1'b0, 32'd0, 1'b0);
        cfg_wr(2'd1, 2'd0, 32'h0000_1800, 1'b0);
        cfg_wr(2'd1, 2'd1, 32'h0000_2800, 1'b0);
        cfg_wr(2'd1, 2'd2, 32'hD, 1'b0);
        cfg_wr(2'd2, 2'd0, 32'h0000_5000, 1'b0);
        cfg_wr(2'd2, 2'd1, 32'h0000_5FFF, 1'b0);
        cfg_wr(2'd2, 2'd2, 32'h3, 1'b0);
        cfg_wr(2'd2, 2'd0, 32'h0000_0000, 1'b1);
        cfg_wr(2'd2, 2'd2, 32'hD, 1'b1);
        tick();
        check("cfg_err_one_cycle", 32'(cfg_err), 32'd0);
        cfg_wr(2'd3, 2'd0, 32'h0000_0000, 1'b1);
        cfg_wr(2'd3, 2'd2, 32'hD, 1'b1);

        foreach (tbl_b[i]) run_vec(tbl_b[i]);

        // Region0 becomes read-only
        set_chk(1'b0, 32'd0, 1'b0);
        cfg_wr(2'd0, 2'd2, 32'h5, 1'b0);
        run_vec('{"r0ro_st",  1'b1, 32'h0000_1500, 1'b1, 1'b0, 2'd0});
        run_vec('{"r0ro_ld",  1'b1, 32'h0000_1500, 1'b0, 1'b1, 2'd0});
        run_vec('{"r1_st_ov", 1'b1, 32'h0000_1900, 1'b1, 1'b1, 2'd1});

        // Counter: clear via out-of-range idx (no error), then saturate
        set_chk(1'b0, 32'd0, 1'b0);
        cfg_wr(2'd3, 2'd3, 32'd0, 1'b0);
        check("cnt_cleared", 32'(hit_cnt), 32'd0);
        exp_cnt = 0;
        set_chk(1'b1, 32'h0000_1500, 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (exp_cnt < 15) exp_cnt++;
            check($sformatf("cnt_burst%0d", i), 32'(hit_cnt), 32'(exp_cnt));
        end
        check("cnt_sat", 32'(hit_cnt), 32'hF);

        // Clear on the locked region's index while a hit lands: clear wins
        cfg_wr(2'd2, 2'd3, 32'd0, 1'b0);
        check("clr_vs_hit.cnt", 32'(hit_cnt), 32'd0);
        check("clr_vs_hit.hit", 32'(res_hit), 32'd1);
        tick();
        check("after_clr.cnt", 32'(hit_cnt), 32'd1);

        // Asynchronous reset in the middle of the hit burst
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        tick();
        check_all_zero("rst_hold");
        set_chk(1'b0, 32'd0, 1'b0);
        rst_n = 1'b1;
        tick();
        check_res("post_rst_idle", 1'b0, 1'b0, 2'd0);
        run_vec('{"post_rst_ld0", 1'b1, 32'h0000_0000, 1'b0, 1'b0, 2'd0});
        run_vec('{"post_rst_r0",  1'b1, 32'h0000_1500, 1'b0, 1'b0, 2'd0});
        check("post_rst_cnt", 32'(hit_cnt), 32'd0);
        set_chk(1'b0, 32'd0, 1'b0);
        cfg_wr(2'd2, 2'd0, 32'h0000_0000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/smc_region_check.md
SMC_REGION_CHECK -- requirements
Module: smc_region_check

Interface
REQ-001 Parameter NUM_REGIONS, default 4, number of independent SMC bound regions (1..16).
REQ-002 Parameter AW, default 32, address width.
REQ-003 Parameter CW, default 16, hit-counter width.
REQ-004 Derived IDXW = max(1, clog2(NUM_REGIONS)).
REQ-005 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-006 Port: clk  in  1  sole clock, rising edge.
REQ-007 Port: rst_n  in  1  asynchronous active-low reset.
REQ-008 Port: cfg_we  in  1  config write strobe, one write per asserted cycle.
REQ-009 Port: cfg_idx  in  IDXW  target region.
REQ-010 Port: cfg_sel  in  2  0=low bound, 1=high bound, 2=ctrl, 3=clear hit counter.
REQ-011 Port: cfg_wdata  in  AW  write data; ctrl uses bit0 enable, bit1 lock, bit2 rd_en, bit3 wr_en.
REQ-012 Port: cfg_err  out  1  one-cycle pulse on a rejected write.
REQ-013 Port: chk_valid  in  1  check request valid.
REQ-014 Port: chk_addr  in  AW  virtual address from CPU.
REQ-015 Port: chk_we  in  1  1=store, 0=load.
REQ-016 Port: res_valid  out  1  result valid.
REQ-017 Port: res_hit  out  1  address inside an enabled, type-matching region.
REQ-018 Port: res_idx  out  IDXW  lowest matching region index; 0 when no hit.
REQ-019 Port: hit_cnt  out  CW  saturating count of hits.

Function
REQ-020 Region r SHALL match when enable, low_r <= chk_addr <= high_r (unsigned, inclusive), and (chk_we ? wr_en : rd_en).
REQ-021 A region with low > high SHALL never match.
REQ-022 Result SHALL be registered: res_valid/res_hit/res_idx reflect the chk_* inputs of the previous cycle (latency 1, throughput 1 per cycle).
REQ-023 When chk_valid=0, the next-cycle res_valid, res_hit and res_idx SHALL all be 0.
REQ-024 On multiple matches, res_idx SHALL be the lowest matching index.
REQ-025 A config write SHALL take effect on the cycle after cfg_we; a check in the same cycle SHALL use the pre-write values.
REQ-026 Each region SHALL have a lock bit, set only via a ctrl write with bit1=1; lock SHALL be cleared only by reset.
REQ-027 A write with cfg_sel 0, 1 or 2 to a locked region SHALL be ignored and SHALL pulse cfg_err the next cycle.
REQ-028 A write with cfg_idx >= NUM_REGIONS SHALL be ignored and SHALL pulse cfg_err.
REQ-029 A cfg_sel=3 write SHALL clear hit_cnt regardless of lock state; cfg_idx is ignored.
REQ-030 hit_cnt SHALL increment when res_hit is registered as 1 and saturate at all-ones.
REQ-031 If a clear and an increment fall on the same cycle, clear SHALL win (hit_cnt=0).

Reset
REQ-032 While rst_n=0, all region bounds, ctrl bits, hit_cnt and all outputs SHALL be 0.
REQ-033 Reset asserted mid-stream SHALL drop any in-flight result; res_valid=0 until the first post-reset check.
REQ-034 Release of rst_n SHALL be synchronised externally; the block needs no extra reset cycles.

Structure
REQ-035 Package smc_pkg SHALL hold the cfg_sel encodings, ctrl bit positions and the default parameters.
REQ-036 Sub-module smc_region_cmp SHALL hold one region's registers and combinational match, instantiated NUM_REGIONS times.
REQ-037 The top SHALL contain the priority encoder, result register, error logic and counter.

Verification
REQ-038 Region0 low=0x1000, high=0x1FFF, ctrl=0xD (enable, rd_en, wr_en); loads at 0x0FFF, 0x1000, 0x1FFF, 0x2000 -> res_hit 0,1,1,0 one cycle later.
REQ-039 Region1 0x1800..0x2800 and Region0 as above, both enabled; load 0x1900 -> res_hit=1, res_idx=0; load 0x2100 -> res_idx=1.
REQ-040 Region2 ctrl=0x3 (lock, enable, rd_en/wr_en=0), then a write to low -> cfg_err pulse, bound unchanged; any check of Region2 -> res_hit=0.
REQ-041 Region0 ctrl=0x5 (rd_en only); store at 0x1500 -> res_hit=0; load at 0x1500 -> res_hit=1.
REQ-042 CW=4; 20 back-to-back hits -> hit_cnt stops at 0xF; a cfg_sel=3 write coincident with a hit -> hit_cnt=0.
REQ-043 Assert rst_n=0 during a burst of hits -> all outputs 0 immediately; after release, bounds are 0 and a load at 0 -> res_hit=0 (region not enabled).
